// File: rtl/sample_dumper.sv
// sample_dumper: reads N samples from a BRAM read port starting at address 0
// and streams each one MSB-byte-first through a byte-wide UART handshake.
`timescale 1ns/1ps

module sample_dumper #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 12,
  parameter int unsigned BYTE_SIZE = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [ADDR_SIZE-1:0] i_count,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  input  logic [DATA_SIZE-1:0] i_mem_data,
  output logic [BYTE_SIZE-1:0] o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned BYTES = DATA_SIZE / BYTE_SIZE;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] count_q, count_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [BYTE_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state and datapath update for the dump sequence.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          count_d = i_count;
          addr_d  = '0;
          state_d = (i_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        shift_d    = i_mem_data;
        byte_cnt_d = CNT_W'(BYTES - 1);
        state_d    = S_SEND;
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (i_tx_done) begin
          if (byte_cnt_q != '0) begin
            shift_d    = shift_q << BYTE_SIZE;
            byte_cnt_d = byte_cnt_q - CNT_W'(1);
            state_d    = S_SEND;
          end else if (addr_q == count_q - ADDR_SIZE'(1)) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_SIZE'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state; the byte on the wire
  // only changes when a new SEND begins, so it holds through WAIT.
  always_comb begin
    tx_data_d = tx_data_q;
    if (state_d == S_SEND) begin
      tx_data_d = shift_d[DATA_SIZE-1 -: BYTE_SIZE];
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_mem_addr = addr_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = (state_q == S_SEND);
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_sample_dumper.sv
// Bench for sample_dumper: transaction-level timing model plus directed and
// randomized dumps against a registered BRAM and a delayed-ack UART.
`timescale 1ns/1ps

module tb_sample_dumper;

  localparam int unsigned DATA_SIZE = 16;
  localparam int unsigned ADDR_SIZE = 12;
  localparam int unsigned BYTE_SIZE = 8;
  localparam int unsigned BYTES     = DATA_SIZE / BYTE_SIZE;

  logic                 clk = 1'b0;
  logic                 i_reset;
  logic                 i_start;
  logic [ADDR_SIZE-1:0] i_count;
  logic [DATA_SIZE-1:0] mem_rd;
  logic                 i_tx_done;
  logic [ADDR_SIZE-1:0] o_mem_addr;
  logic [BYTE_SIZE-1:0] o_tx_data;
  logic                 o_tx_start;
  logic                 o_busy;
  logic                 o_done;

  always #5 clk = ~clk;

  sample_dumper #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE),
    .BYTE_SIZE(BYTE_SIZE)
  ) dut (
    .i_clock   (clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_count   (i_count),
    .o_mem_addr(o_mem_addr),
    .i_mem_data(mem_rd),
    .o_tx_data (o_tx_data),
    .o_tx_start(o_tx_start),
    .i_tx_done (i_tx_done),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  // Sample memory with one cycle of read latency.
  logic [DATA_SIZE-1:0] mem [0:(1<<ADDR_SIZE)-1];
  always @(posedge clk) mem_rd <= mem[o_mem_addr];

  int total = 0;
  int bad   = 0;

  // Reference model: cycle index of each expected event, derived from the
  // timing rules (first byte 2 cycles after acceptance, next byte on the ack
  // edge, next sample 2 cycles after the ack edge, done the cycle after).
  int                   cyc = 0;
  bit                   started = 1'b0;
  bit                   m_busy;
  int                   m_addr;
  int                   start_at, done_at, busy_off_at, zero_addr_at, last_send;
  bit                   waiting, sent_since_rst;
  int                   in_sample, samples_left;
  logic [BYTE_SIZE-1:0] exp_data;
  logic [BYTE_SIZE-1:0] q_bytes [$];

  always @(posedge clk) begin : model
    bit                   was_busy;
    int                   n;
    logic [DATA_SIZE-1:0] v;
    cyc     = cyc + 1;
    started = 1'b1;
    if (i_reset === 1'b1) begin
      m_busy = 1'b0; m_addr = 0;
      start_at = -1; done_at = -1; busy_off_at = -1; zero_addr_at = -1;
      last_send = -10; waiting = 1'b0; sent_since_rst = 1'b0;
      exp_data = '0; q_bytes.delete(); in_sample = 0; samples_left = 0;
    end else begin
      was_busy = m_busy;
      if (cyc == busy_off_at) m_busy = 1'b0;
      if (cyc == zero_addr_at) m_addr = 0;
      if (!was_busy && i_start === 1'b1) begin
        n = int'(i_count);
        q_bytes.delete();
        for (int s = 0; s < n; s++) begin
          v = mem[s];
          for (int b = int'(BYTES) - 1; b >= 0; b--)
            q_bytes.push_back(BYTE_SIZE'(v >> (b * int'(BYTE_SIZE))));
        end
        m_busy = 1'b1; m_addr = 0;
        if (n == 0) begin
          done_at = cyc + 1; busy_off_at = cyc + 1;
        end else begin
          start_at = cyc + 2; samples_left = n - 1; in_sample = int'(BYTES);
        end
      end else if (waiting && i_tx_done === 1'b1 && cyc >= last_send + 2) begin
        waiting = 1'b0;
        if (in_sample > 0) begin
          start_at = cyc;
        end else if (samples_left > 0) begin
          samples_left--; in_sample = int'(BYTES); m_addr++; start_at = cyc + 2;
        end else begin
          done_at = cyc + 1; busy_off_at = cyc + 1; zero_addr_at = cyc + 1;
        end
      end
      if (cyc == start_at) begin
        exp_data = q_bytes.pop_front();
        in_sample--; waiting = 1'b1; sent_since_rst = 1'b1; last_send = cyc;
      end
    end
  end

  // Monitor state and UART responder controls (all owned by the main process).
  int                   tx_cnt = 0, done_cnt = 0, max_addr = 0;
  logic [BYTE_SIZE-1:0] byte_log [$];
  int                   addr_log [$];
  int                   tx_cyc_log [$];
  int                   uart_delay, uart_fire;
  bit                   uart_stall, spur_coinc;
  int unsigned          spur_rate;

  logic [BYTE_SIZE-1:0] exp1  [6] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
  int                   expa1 [6] = '{0, 0, 1, 1, 2, 2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: compare against the model, log transfers, drive the UART ack.
  task automatic tick();
    @(negedge clk);
    if (started) begin
      chk("busy", 32'(o_busy), 32'(m_busy));
      chk("done", 32'(o_done), 32'(cyc == done_at));
      chk("tx_start", 32'(o_tx_start), 32'(cyc == start_at));
      chk("mem_addr", 32'(o_mem_addr), 32'(m_addr));
      if (waiting || !sent_since_rst) chk("tx_data", 32'(o_tx_data), 32'(exp_data));
    end
    if (o_tx_start === 1'b1) begin
      tx_cnt++;
      byte_log.push_back(o_tx_data);
      addr_log.push_back(int'(o_mem_addr));
      tx_cyc_log.push_back(cyc);
      if (int'(o_mem_addr) > max_addr) max_addr = int'(o_mem_addr);
      uart_fire = cyc + uart_delay;
    end
    if (o_done === 1'b1) done_cnt++;
    i_tx_done = 1'b0;
    if (!uart_stall && cyc == uart_fire) i_tx_done = 1'b1;
    if (spur_coinc && o_tx_start === 1'b1) i_tx_done = 1'b1;
    if (spur_rate != 0 && $urandom_range(99, 0) < spur_rate) i_tx_done = 1'b1;
  endtask

  task automatic pulse_start(input int cnt);
    i_start = 1'b1;
    i_count = ADDR_SIZE'(cnt);
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (o_done !== 1'b1 && n < budget) begin tick(); n++; end
    chk(nm, 32'(o_done === 1'b1), 32'd1);
  endtask

  task automatic wait_tx(input int target, input int budget, input string nm);
    int n = 0;
    while (tx_cnt < target && n < budget) begin tick(); n++; end
    chk(nm, 32'(tx_cnt >= target), 32'd1);
  endtask

  task automatic check_bytes(input int b0, input int nsamp, input string nm);
    int idx = b0;
    chk({nm, "_count"}, 32'(byte_log.size() - b0), 32'(nsamp * int'(BYTES)));
    if (byte_log.size() - b0 == nsamp * int'(BYTES)) begin
      for (int s = 0; s < nsamp; s++)
        for (int b = int'(BYTES) - 1; b >= 0; b--) begin
          chk(nm, 32'(byte_log[idx]), 32'(BYTE_SIZE'(mem[s] >> (b * int'(BYTE_SIZE)))));
          idx++;
        end
    end
  endtask

  initial begin
    int b0, d0, t0, k0, lat, n;
    i_reset = 1'b1; i_start = 1'b0; i_count = '0; i_tx_done = 1'b0;
    uart_delay = 5; uart_fire = -1; uart_stall = 1'b0; spur_coinc = 1'b0; spur_rate = 0;
    for (int a = 0; a < (1 << ADDR_SIZE); a++) mem[a] = '0;

    // Reset values.
    tick();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_tx_start", 32'(o_tx_start), 32'd0);
    chk("rst_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_tx_data", 32'(o_tx_data), 32'd0);
    tick();
    i_reset = 1'b0;
    repeat (2) tick();

    // Three-sample dump with known data and UART ack after 5 cycles.
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h00FF;
    b0 = byte_log.size(); d0 = done_cnt;
    pulse_start(3);
    k0 = cyc;
    wait_done(500, "t1_done_seen");
    repeat (2) tick();
    chk("t1_busy_after", 32'(o_busy), 32'd0);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t1_nbytes", 32'(byte_log.size() - b0), 32'd6);
    if (byte_log.size() - b0 == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("t1_byte", 32'(byte_log[b0 + i]), 32'(exp1[i]));
        chk("t1_addr", 32'(addr_log[b0 + i]), 32'(expa1[i]));
      end
      chk("t1_first_lat", 32'(tx_cyc_log[b0] - k0), 32'd2);
      chk("t1_byte_gap", 32'(tx_cyc_log[b0 + 1] - tx_cyc_log[b0]), 32'd6);
      chk("t1_sample_gap", 32'(tx_cyc_log[b0 + 2] - tx_cyc_log[b0 + 1]), 32'd8);
    end

    // Zero-length dump.
    d0 = done_cnt; t0 = tx_cnt;
    i_start = 1'b1; i_count = '0;
    lat = 0;
    do begin tick(); i_start = 1'b0; lat++; end while (o_done !== 1'b1 && lat < 10);
    chk("t2_done_lat", 32'(lat), 32'd2);
    chk("t2_addr", 32'(o_mem_addr), 32'd0);
    repeat (3) tick();
    chk("t2_no_tx", 32'(tx_cnt - t0), 32'd0);
    chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Extra starts while busy are ignored.
    mem[0] = 16'($urandom); mem[1] = 16'($urandom);
    b0 = byte_log.size(); d0 = done_cnt;
    pulse_start(2);
    repeat (4) tick();
    pulse_start(7);
    repeat (10) tick();
    pulse_start(1);
    wait_done(500, "t3_done_seen");
    repeat (3) tick();
    chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_bytes(b0, 2, "t3_bytes");

    // UART stalls for 1000 cycles in WAIT.
    mem[0] = 16'($urandom); mem[1] = 16'($urandom);
    b0 = byte_log.size(); t0 = tx_cnt;
    uart_stall = 1'b1;
    pulse_start(2);
    wait_tx(t0 + 1, 50, "t4_first_tx");
    repeat (1001) tick();
    chk("t4_stall_data", 32'(o_tx_data), 32'(mem[0][15:8]));
    chk("t4_stall_addr", 32'(o_mem_addr), 32'd0);
    chk("t4_stall_ntx", 32'(tx_cnt - t0), 32'd1);
    chk("t4_stall_busy", 32'(o_busy), 32'd1);
    uart_stall = 1'b0;
    uart_fire = cyc + 1;
    wait_done(500, "t4_done_seen");
    tick();
    check_bytes(b0, 2, "t4_bytes");

    // Reset in the middle of a four-sample dump.
    for (int a = 0; a < 4; a++) mem[a] = 16'($urandom);
    t0 = tx_cnt;
    pulse_start(4);
    wait_tx(t0 + 3, 300, "t5_third_tx");
    repeat (2) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("t5_busy", 32'(o_busy), 32'd0);
    chk("t5_tx_start", 32'(o_tx_start), 32'd0);
    chk("t5_addr", 32'(o_mem_addr), 32'd0);
    d0 = done_cnt; t0 = tx_cnt;
    repeat (20) tick();
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_no_tx", 32'(tx_cnt - t0), 32'd0);
    mem[0] = 16'($urandom);
    b0 = byte_log.size();
    pulse_start(1);
    wait_done(200, "t5_done_seen");
    tick();
    check_bytes(b0, 1, "t5_bytes");

    // Spurious acks in IDLE and coincident with the transmit request.
    t0 = tx_cnt;
    spur_rate = 40;
    repeat (30) tick();
    spur_rate = 0;
    chk("t6_idle_no_tx", 32'(tx_cnt - t0), 32'd0);
    chk("t6_idle_busy", 32'(o_busy), 32'd0);
    for (int a = 0; a < 3; a++) mem[a] = 16'($urandom);
    b0 = byte_log.size();
    spur_coinc = 1'b1;
    pulse_start(3);
    wait_done(500, "t6_done_seen");
    spur_coinc = 1'b0;
    tick();
    check_bytes(b0, 3, "t6_bytes");

    // Randomized dumps with random ack delays and spurious acks.
    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(6, 1));
      for (int a = 0; a < 8; a++) mem[a] = 16'($urandom);
      uart_delay = int'($urandom_range(6, 1));
      spur_rate = $urandom_range(10, 0);
      spur_coinc = 1'($urandom_range(1, 0));
      d0 = done_cnt;
      pulse_start(n);
      wait_done(2000, "rnd_done_seen");
      spur_rate = 0; spur_coinc = 1'b0;
      repeat (int'($urandom_range(4, 2))) tick();
      chk("rnd_done_cnt", 32'(done_cnt - d0), 32'd1);
    end

    // Full-depth dump: addresses 0..4094, no wrap.
    for (int a = 0; a < (1 << ADDR_SIZE); a++) mem[a] = 16'($urandom);
    uart_delay = 1;
    max_addr = 0; t0 = tx_cnt;
    pulse_start((1 << ADDR_SIZE) - 1);
    wait_done(60000, "full_done_seen");
    repeat (2) tick();
    chk("full_ntx", 32'(tx_cnt - t0), 32'd8190);
    chk("full_max_addr", 32'(max_addr), 32'd4094);
    chk("full_addr_after", 32'(o_mem_addr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
